// File: rtl/usb_cdc_bridge_packet_rx_pkg.sv
// Shared constants, enums and the CRC-8 step for the bridge packet receiver.
package usb_cdc_bridge_packet_rx_pkg;

  localparam logic [7:0]  BRIDGE_PACKET_HEADER = 8'h5A;
  localparam int unsigned BRIDGE_PACKET_SIZE   = 8;
  localparam int unsigned FLASH_PAGE_SIZE      = 256;

  localparam logic [2:0] INVALID_BCMD                   = 3'd0;
  localparam logic [2:0] EXECUTE_FLASH_CMD_BCMD         = 3'd1;
  localparam logic [2:0] EXECUTE_FLASH_WR_REG_BCMD      = 3'd2;
  localparam logic [2:0] EXECUTE_FLASH_PROGRAM_MEM_BCMD = 3'd3;
  localparam logic [2:0] EXECUTE_FLASH_RD_REG_BCMD      = 3'd4;
  localparam logic [2:0] EXECUTE_FLASH_READ_MEM_BCMD    = 3'd5;
  localparam logic [2:0] RESERVE_0_BCMD                 = 3'd6;
  localparam logic [2:0] RESERVE_1_BCMD                 = 3'd7;

  localparam logic [4:0] L_1B   = 5'd1;
  localparam logic [4:0] L_256B = 5'd31;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CRC     = 2'd1,
    ERR_BCMD    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } t_rx_err;

  typedef enum logic [2:0] {
    S_HUNT,
    S_COLLECT,
    S_CHECK,
    S_ISSUE,
    S_PAYLOAD,
    S_PL_CRC
  } t_rx_state;

  // CRC-8, poly 0x07, MSB first, one byte per call
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_cdc_bridge_packet_rx_if.sv
// Byte stream in, decoded command, payload stream and error report of the packet receiver.
interface usb_cdc_bridge_packet_rx_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_bcmd;
  logic [4:0]  cmd_len;
  logic [7:0]  cmd_fcmd;
  logic [31:0] cmd_arg;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        pl_last;
  logic        pl_done;
  logic        err_valid;
  logic [1:0]  err_code;

  // master is the receiver itself, slave is its surrounding (CDC source, executor, page sink)
  modport master (
    input  rx_data, rx_valid, cmd_ready, pl_ready,
    output rx_ready, cmd_valid, cmd_bcmd, cmd_len, cmd_fcmd, cmd_arg,
           pl_data, pl_valid, pl_last, pl_done, err_valid, err_code
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready, pl_ready,
    input  rx_ready, cmd_valid, cmd_bcmd, cmd_len, cmd_fcmd, cmd_arg,
           pl_data, pl_valid, pl_last, pl_done, err_valid, err_code
  );
endinterface

// File: rtl/usb_cdc_bridge_crc8.sv
// CRC-8 accumulator; clr together with en restarts the sum with din as first byte.
module usb_cdc_bridge_crc8
  import usb_cdc_bridge_packet_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= en ? crc8_next(8'h00, din) : 8'h00;
    end else if (en) begin
      crc <= crc8_next(crc, din);
    end
  end

endmodule

// File: rtl/usb_cdc_bridge_packet_rx.sv
// Hunts 0x5A headers, assembles and validates 8-byte bridge packets, issues the command and
// forwards the program-page payload with its trailing CRC check.
module usb_cdc_bridge_packet_rx
  import usb_cdc_bridge_packet_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter bit          CRC_CHECK_EN   = 1'b1
) (
  input logic                        clk,
  input logic                        rst_n,
  usb_cdc_bridge_packet_rx_if.master bus
);

  localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    IDX_CRC  = 3'(BRIDGE_PACKET_SIZE - 1);
  localparam logic [7:0]    PL_LAST  = 8'(FLASH_PAGE_SIZE - 1);

  t_rx_state     state, state_nxt;
  t_rx_err       err_q, err_nxt;
  logic          armed, done_q, done_nxt;
  logic          rdy, accept, timed, bcmd_bad, crc_clr, crc_en;
  logic [2:0]    idx;
  logic [7:0]    pl_cnt, crc_byte, crc_val;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    bcmd_q;
  logic [4:0]    len_q;
  logic [7:0]    fcmd_q;
  logic [31:0]   arg_q;

  usb_cdc_bridge_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (bus.rx_data),
    .crc   (crc_val)
  );

  assign timed    = state inside {S_COLLECT, S_PAYLOAD, S_PL_CRC};
  assign bcmd_bad = (bcmd_q inside {INVALID_BCMD, RESERVE_0_BCMD, RESERVE_1_BCMD}) ||
                    ((bcmd_q == EXECUTE_FLASH_RD_REG_BCMD) && (len_q == L_1B));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_NONE;
    done_nxt  = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    rdy       = 1'b0;
    // armed holds rx_ready low until the first edge after reset release
    case (state)
      S_HUNT, S_COLLECT, S_PL_CRC: rdy = armed;
      S_PAYLOAD:                   rdy = armed & bus.pl_ready;
      default:                     rdy = 1'b0;
    endcase
    accept = bus.rx_valid & rdy;

    case (state)
      S_HUNT: begin
        if (accept && (bus.rx_data == BRIDGE_PACKET_HEADER)) begin
          crc_clr   = 1'b1;
          crc_en    = 1'b1;
          state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          if (idx == IDX_CRC) state_nxt = S_CHECK;
          else                crc_en    = 1'b1;
        end
      end
      S_CHECK: begin
        if (CRC_CHECK_EN && (crc_byte != crc_val)) begin
          err_nxt   = ERR_CRC;
          state_nxt = S_HUNT;
        end else if (bcmd_bad) begin
          err_nxt   = ERR_BCMD;
          state_nxt = S_HUNT;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready) begin
          if (bcmd_q == EXECUTE_FLASH_PROGRAM_MEM_BCMD) begin
            crc_clr   = 1'b1;
            state_nxt = S_PAYLOAD;
          end else begin
            state_nxt = S_HUNT;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          crc_en = 1'b1;
          if (pl_cnt == PL_LAST) state_nxt = S_PL_CRC;
        end
      end
      S_PL_CRC: begin
        if (accept) begin
          if (!CRC_CHECK_EN || (bus.rx_data == crc_val)) done_nxt = 1'b1;
          else                                           err_nxt  = ERR_CRC;
          state_nxt = S_HUNT;
        end
      end
      default: state_nxt = S_HUNT;
    endcase

    if (timed && !accept && (tmo_cnt == TMO_LAST)) begin
      err_nxt   = ERR_TIMEOUT;
      state_nxt = S_HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      err_q   <= ERR_NONE;
      done_q  <= 1'b0;
      tmo_cnt <= '0;
      idx     <= '0;
      pl_cnt  <= '0;
    end else begin
      armed  <= 1'b1;
      err_q  <= err_nxt;
      done_q <= done_nxt;
      if (!timed || accept) tmo_cnt <= '0;
      else                  tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_HUNT)                  idx <= 3'd1;
      else if (state == S_COLLECT && accept) idx <= idx + 3'd1;
      if (state == S_ISSUE)                  pl_cnt <= '0;
      else if (state == S_PAYLOAD && accept) pl_cnt <= pl_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcmd_q   <= '0;
      len_q    <= '0;
      fcmd_q   <= '0;
      arg_q    <= '0;
      crc_byte <= '0;
    end else if (state == S_COLLECT && accept) begin
      case (idx)
        3'd1:    {len_q, bcmd_q} <= bus.rx_data;
        3'd2:    fcmd_q          <= bus.rx_data;
        3'd7:    crc_byte        <= bus.rx_data;
        default: arg_q           <= {arg_q[23:0], bus.rx_data};
      endcase
    end
  end

  assign bus.rx_ready  = rdy;
  assign bus.cmd_valid = (state == S_ISSUE);
  assign bus.cmd_bcmd  = bcmd_q;
  assign bus.cmd_len   = len_q;
  assign bus.cmd_fcmd  = fcmd_q;
  assign bus.cmd_arg   = arg_q;
  assign bus.pl_valid  = (state == S_PAYLOAD) & bus.rx_valid;
  assign bus.pl_data   = (state == S_PAYLOAD) ? bus.rx_data : '0;
  assign bus.pl_last   = (state == S_PAYLOAD) && (pl_cnt == PL_LAST);
  assign bus.pl_done   = done_q;
  assign bus.err_valid = (err_q != ERR_NONE);
  assign bus.err_code  = err_q;

endmodule

// File: tb/tb_usb_cdc_bridge_packet_rx.sv
// Directed bench: one receiver with CRC checking, one without, fed the same byte stream.
module tb_usb_cdc_bridge_packet_rx;

  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       pl_ready = 1'b0;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_cnt = 0;
  int         done_cnt = 0;
  logic [1:0] last_err = '0;

  usb_cdc_bridge_packet_rx_if ifa ();
  usb_cdc_bridge_packet_rx_if ifb ();

  assign ifa.rx_data   = rx_data;
  assign ifa.rx_valid  = rx_valid;
  assign ifa.cmd_ready = cmd_ready;
  assign ifa.pl_ready  = pl_ready;
  assign ifb.rx_data   = rx_data;
  assign ifb.rx_valid  = rx_valid;
  assign ifb.cmd_ready = cmd_ready;
  assign ifb.pl_ready  = pl_ready;

  usb_cdc_bridge_packet_rx #(.TIMEOUT_CYCLES(TMO), .CRC_CHECK_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  usb_cdc_bridge_packet_rx #(.TIMEOUT_CYCLES(TMO), .CRC_CHECK_EN(1'b0)) dut_nocrc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.err_valid) begin
      err_cnt  <= err_cnt + 1;
      last_err <= ifa.err_code;
    end
    if (ifa.pl_done) done_cnt <= done_cnt + 1;
  end

  // bit-serial reference: shift message bits in MSB first against poly 0x07
  function automatic logic [7:0] crc8_bits(input logic [7:0] crc_in, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  function automatic logic [7:0] pkt_crc(input logic [7:0] b1, b2, b3, b4, b5, b6);
    logic [7:0] c;
    c = crc8_bits(8'h00, 8'h5A);
    c = crc8_bits(c, b1);
    c = crc8_bits(c, b2);
    c = crc8_bits(c, b3);
    c = crc8_bits(c, b4);
    c = crc8_bits(c, b5);
    c = crc8_bits(c, b6);
    return c;
  endfunction

  // called and returning just after a rising edge
  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (ifa.rx_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_%02h: rx_ready=%b after 50 cycles, required 1", b, ifa.rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b1, b2, b3, b4, b5, b6, input logic [7:0] crc_flip);
    logic [7:0] c;
    c = pkt_crc(b1, b2, b3, b4, b5, b6) ^ crc_flip;
    send_byte(8'h5A);
    send_byte(b1); send_byte(b2); send_byte(b3);
    send_byte(b4); send_byte(b5); send_byte(b6);
    send_byte(c);
  endtask

  task automatic expect_cmd(input string name, input logic [2:0] bcmd, input logic [4:0] len,
                            input logic [7:0] fcmd, input logic [31:0] arg);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (ifa.cmd_valid !== 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if ({ifa.cmd_valid, ifa.cmd_bcmd, ifa.cmd_len, ifa.cmd_fcmd, ifa.cmd_arg} !== {1'b1, bcmd, len, fcmd, arg}) begin
      n_bad++;
      $display("FAIL %s: valid=%b bcmd=%0d len=%0d fcmd=%02h arg=%08h, required valid=1 bcmd=%0d len=%0d fcmd=%02h arg=%08h",
               name, ifa.cmd_valid, ifa.cmd_bcmd, ifa.cmd_len, ifa.cmd_fcmd, ifa.cmd_arg, bcmd, len, fcmd, arg);
    end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ifa.cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_release: cmd_valid=%b after handshake, required 0", name, ifa.cmd_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ifa.rx_ready, ifa.cmd_valid, ifa.pl_valid, ifa.pl_last, ifa.pl_done, ifa.err_valid, ifa.err_code} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b cv=%b plv=%b pll=%b pld=%b ev=%b ec=%0d, required all 0",
               ifa.rx_ready, ifa.cmd_valid, ifa.pl_valid, ifa.pl_last, ifa.pl_done, ifa.err_valid, ifa.err_code);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ifa.rx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_ready: rx_ready=%b before first edge, required 0", ifa.rx_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({ifa.rx_ready, ifa.cmd_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_hunt_ready: rx_ready=%b cmd_valid=%b, required 1 0", ifa.rx_ready, ifa.cmd_valid);
    end
  endtask

  task automatic test_hunt_wr_reg();
    int e0;
    e0 = err_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    n_cmp++;
    if ({ifa.cmd_valid, ifa.rx_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL hunt_drop: cmd_valid=%b rx_ready=%b, required 0 1", ifa.cmd_valid, ifa.rx_ready);
    end
    @(posedge clk); #1;
    send_packet(8'h0A, 8'h06, 8'hC3, 8'h5E, 8'h71, 8'h9D, 8'h00);
    expect_cmd("wr_reg", 3'd2, 5'd1, 8'h06, 32'hC35E719D);
    n_cmp++;
    if (err_cnt != e0) begin
      n_bad++;
      $display("FAIL wr_reg_no_err: %0d error pulses, required 0", err_cnt - e0);
    end
  endtask

  task automatic test_crc_error();
    int e0;
    e0 = err_cnt;
    send_packet(8'h0A, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (ifa.cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL crc_no_cmd: cmd_valid=%b, required 0", ifa.cmd_valid);
    end
    n_cmp++;
    if ({ifb.cmd_valid, ifb.cmd_bcmd, ifb.cmd_len, ifb.cmd_fcmd, ifb.cmd_arg} !== {1'b1, 3'd2, 5'd1, 8'h06, 32'h11223344}) begin
      n_bad++;
      $display("FAIL nocrc_accept: valid=%b bcmd=%0d len=%0d fcmd=%02h arg=%08h, required 1 2 1 06 11223344",
               ifb.cmd_valid, ifb.cmd_bcmd, ifb.cmd_len, ifb.cmd_fcmd, ifb.cmd_arg);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (err_cnt != e0 + 1 || last_err !== 2'd1) begin
      n_bad++;
      $display("FAIL crc_err: pulses=%0d code=%0d, required 1 code 1", err_cnt - e0, last_err);
    end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    send_packet(8'h0A, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
    expect_cmd("crc_recover", 3'd2, 5'd1, 8'h06, 32'h11223344);
  endtask

  task automatic test_program_mem();
    int unsigned n;
    int          e0, d0, stall;
    logic        acc;
    logic [7:0]  pcrc;
    send_packet(8'hFB, 8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
    n = 0;
    @(negedge clk);
    while (ifa.cmd_valid !== 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if ({ifa.rx_ready, ifa.cmd_valid, ifa.cmd_bcmd, ifa.cmd_len, ifa.cmd_fcmd, ifa.cmd_arg} !==
          {1'b0, 1'b1, 3'd3, 5'd31, 8'h12, 32'h01020304}) begin
        n_bad++;
        $display("FAIL prog_stall_%0d: rdy=%b valid=%b bcmd=%0d len=%0d fcmd=%02h arg=%08h, required 0 1 3 31 12 01020304",
                 k, ifa.rx_ready, ifa.cmd_valid, ifa.cmd_bcmd, ifa.cmd_len, ifa.cmd_fcmd, ifa.cmd_arg);
      end
      @(negedge clk);
    end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    pcrc = 8'h00;
    for (int i = 0; i < 256; i++) begin
      pcrc     = crc8_bits(pcrc, 8'(i));
      rx_data  = 8'(i);
      rx_valid = 1'b1;
      stall    = 0;
      do begin
        pl_ready = (stall >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        acc      = pl_ready;
        @(negedge clk);
        n_cmp++;
        if ({ifa.pl_valid, ifa.rx_ready, ifa.pl_data, ifa.pl_last} !== {1'b1, pl_ready, 8'(i), (i == 255)}) begin
          n_bad++;
          $display("FAIL payload_%0d: pl_valid=%b rx_ready=%b pl_data=%02h pl_last=%b, required 1 %b %02h %b",
                   i, ifa.pl_valid, ifa.rx_ready, ifa.pl_data, ifa.pl_last, pl_ready, 8'(i), (i == 255));
        end
        @(posedge clk); #1;
        stall++;
      end while (!acc);
    end
    rx_valid = 1'b0;
    pl_ready = 1'b0;
    e0 = err_cnt;
    d0 = done_cnt;
    send_byte(pcrc);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != d0 + 1 || err_cnt != e0) begin
      n_bad++;
      $display("FAIL pl_done: done pulses=%0d err pulses=%0d, required 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_bad_bcmd();
    logic [7:0] vec [2];
    int         e0;
    vec[0] = 8'h0C;
    vec[1] = 8'h06;
    for (int v = 0; v < 2; v++) begin
      e0 = err_cnt;
      send_packet(vec[v], 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (err_cnt != e0 + 1 || last_err !== 2'd2 || ifa.cmd_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL bad_bcmd_%02h: pulses=%0d code=%0d cmd_valid=%b, required 1 code 2 valid 0",
                 vec[v], err_cnt - e0, last_err, ifa.cmd_valid);
      end
    end
  endtask

  task automatic test_timeout();
    int   e0;
    logic exp;
    send_byte(8'h5A);
    send_byte(8'h0A);
    send_byte(8'h06);
    for (int n = 1; n <= TMO + 1; n++) begin
      @(negedge clk);
      exp = (n == TMO + 1);
      n_cmp++;
      if (ifa.err_valid !== exp || (exp && ifa.err_code !== 2'd3)) begin
        n_bad++;
        $display("FAIL timeout_cycle_%0d: err_valid=%b err_code=%0d, required %b code 3", n, ifa.err_valid, ifa.err_code, exp);
      end
    end
    @(posedge clk); #1;

    e0 = err_cnt;
    send_byte(8'h5A);
    send_byte(8'h0A);
    send_byte(8'h06);
    repeat (TMO - 1) @(posedge clk);
    #1;
    rx_data  = 8'hA1;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ifa.err_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_expiry_byte: err_valid=%b code=%0d, required 0", ifa.err_valid, ifa.err_code);
    end
    @(posedge clk); #1;
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    send_byte(pkt_crc(8'h0A, 8'h06, 8'hA1, 8'hA2, 8'hA3, 8'hA4));
    expect_cmd("timeout_survivor", 3'd2, 5'd1, 8'h06, 32'hA1A2A3A4);
    n_cmp++;
    if (err_cnt != e0) begin
      n_bad++;
      $display("FAIL timeout_suppressed: %0d error pulses, required 0", err_cnt - e0);
    end
  endtask

  task automatic test_reset_payload();
    int e0;
    send_packet(8'hFB, 8'h12, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00);
    expect_cmd("prog_before_reset", 3'd3, 5'd31, 8'h12, 32'h00001000);
    pl_ready = 1'b1;
    for (int i = 0; i < 100; i++) send_byte(8'(i));
    rx_data  = 8'd100;
    rx_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ifa.rx_ready, ifa.cmd_valid, ifa.cmd_bcmd, ifa.cmd_len, ifa.cmd_fcmd, ifa.cmd_arg, ifa.pl_data,
         ifa.pl_valid, ifa.pl_last, ifa.pl_done, ifa.err_valid, ifa.err_code} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_payload: rdy=%b cv=%b arg=%08h pl_data=%02h plv=%b pll=%b ev=%b, required all 0",
               ifa.rx_ready, ifa.cmd_valid, ifa.cmd_arg, ifa.pl_data, ifa.pl_valid, ifa.pl_last, ifa.err_valid);
    end
    rx_valid = 1'b0;
    pl_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    e0 = err_cnt;
    send_packet(8'h0A, 8'h06, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00);
    expect_cmd("after_reset", 3'd2, 5'd1, 8'h06, 32'hDEADBEEF);
    n_cmp++;
    if (err_cnt != e0) begin
      n_bad++;
      $display("FAIL after_reset_no_err: %0d error pulses, required 0", err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_hunt_wr_reg();
    test_crc_error();
    test_program_mem();
    test_bad_bcmd();
    test_timeout();
    test_reset_payload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
